// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage, 16x32 register file, RAW scoreboard.
// Commits MEM/WB results, bypasses same-cycle writes, counts retires.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   wb_memtoreg, wb_regwrite select mem/alu value, commit enable
//   wb_mem, wb_alu, wb_rd    writeback data sources and destination
//   rs1, rs2 -> rd1, rd2     decode read ports (write-through bypass)
//   iss_valid, iss_rd        decode issue of a register writer
//   use_rs1, use_rs2         issuing instruction reads rs1 / rs2
//   stall                    decode must hold (RAW or scoreboard full)
//   dbg_idx -> dbg_data      raw register read, no bypass
//   retired                  committed register write count
module wb_regfile #(
    parameter int NREG = 16,
    parameter int DW   = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_memtoreg,
    input  logic          wb_regwrite,
    input  logic [DW-1:0] wb_mem,
    input  logic [DW-1:0] wb_alu,
    input  logic [AW-1:0] wb_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic          use_rs1,
    input  logic          use_rs2,
    output logic          stall,
    input  logic [AW-1:0] dbg_idx,
    output logic [DW-1:0] dbg_data,
    output logic [31:0]   retired
);

    logic [DW-1:0] regs [NREG];
    logic [1:0]    pend [NREG];

    logic [DW-1:0] wb_val;
    logic          hit1;
    logic          hit2;
    logic          byp1;
    logic          byp2;
    logic          raw;
    logic          full;
    logic          accept;

    assign wb_val = wb_memtoreg ? wb_mem : wb_alu;

    assign hit1 = wb_regwrite && (wb_rd == rs1);
    assign hit2 = wb_regwrite && (wb_rd == rs2);

    assign rd1      = hit1 ? wb_val : regs[rs1];
    assign rd2      = hit2 ? wb_val : regs[rs2];
    assign dbg_data = regs[dbg_idx];

    // A commit retiring the last outstanding writer resolves the hazard
    // in the same cycle; with more writers in flight the value is stale.
    assign byp1 = hit1 && (pend[rs1] == 2'd1);
    assign byp2 = hit2 && (pend[rs2] == 2'd1);

    assign raw = (use_rs1 && (pend[rs1] != 2'd0) && !byp1)
              || (use_rs2 && (pend[rs2] != 2'd0) && !byp2);

    assign full = iss_valid && (pend[iss_rd] == 2'd3);

    assign stall  = raw || full;
    assign accept = iss_valid && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_regwrite) begin
            regs[wb_rd] <= wb_val;
        end
    end

    // Issue and commit to the same register cancel out. A commit with
    // nothing pending (e.g. after a mid-flight reset) leaves pend at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                pend[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                unique case ({accept && (iss_rd == AW'(i)),
                              wb_regwrite && (wb_rd == AW'(i))})
                    2'b10: pend[i] <= pend[i] + 2'd1;
                    2'b01: begin
                        if (pend[i] != 2'd0) begin
                            pend[i] <= pend[i] - 2'd1;
                        end
                    end
                    default: pend[i] <= pend[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (wb_regwrite) begin
            retired <= retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vectors for wb_regfile.
// Expectations are queued by stimulus and checked by a monitor.
module tb_wb_regfile;

    localparam int S_RD1 = 0;
    localparam int S_RD2 = 1;
    localparam int S_DBG = 2;
    localparam int S_RET = 3;
    localparam int S_STL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_memtoreg;
    logic        wb_regwrite;
    logic [31:0] wb_mem;
    logic [31:0] wb_alu;
    logic [3:0]  wb_rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        stall;
    logic [3:0]  dbg_idx;
    logic [31:0] dbg_data;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    int          q_sel  [$];
    logic [31:0] q_exp  [$];
    string       q_name [$];

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .wb_memtoreg(wb_memtoreg),
        .wb_regwrite(wb_regwrite),
        .wb_mem     (wb_mem),
        .wb_alu     (wb_alu),
        .wb_rd      (wb_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd1        (rd1),
        .rd2        (rd2),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .use_rs1    (use_rs1),
        .use_rs2    (use_rs2),
        .stall      (stall),
        .dbg_idx    (dbg_idx),
        .dbg_data   (dbg_data),
        .retired    (retired)
    );

    task automatic chk(input int sel, input logic [31:0] v,
                       input string n);
        q_sel.push_back(sel);
        q_exp.push_back(v);
        q_name.push_back(n);
    endtask

    // Advance to the next negedge and return all inputs to idle.
    task automatic nxt();
        @(negedge clk);
        wb_memtoreg = 1'b0;
        wb_regwrite = 1'b0;
        wb_mem      = '0;
        wb_alu      = '0;
        wb_rd       = '0;
        rs1         = '0;
        rs2         = '0;
        iss_valid   = 1'b0;
        iss_rd      = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        dbg_idx     = '0;
    endtask

    task automatic commit(input logic [3:0] rd, input logic m2r,
                          input logic [31:0] mem,
                          input logic [31:0] alu);
        wb_regwrite = 1'b1;
        wb_rd       = rd;
        wb_memtoreg = m2r;
        wb_mem      = mem;
        wb_alu      = alu;
    endtask

    task automatic issue(input logic [3:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
    endtask

    // Monitor: outputs are settled 2 time units after each negedge,
    // well before the commit edge.
    initial begin
        logic [31:0] act;
        forever begin
            @(negedge clk);
            #2;
            while (q_sel.size() > 0) begin
                int          s;
                logic [31:0] e;
                string       n;
                s = q_sel.pop_front();
                e = q_exp.pop_front();
                n = q_name.pop_front();
                case (s)
                    S_RD1:   act = rd1;
                    S_RD2:   act = rd2;
                    S_DBG:   act = dbg_data;
                    S_RET:   act = retired;
                    default: act = {31'd0, stall};
                endcase
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, act, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held
        nxt();
        rst = 1'b1;
        chk(S_RD1, 32'h0, "rst_rd1");
        chk(S_RET, 32'h0, "rst_retired");
        chk(S_STL, 32'h0, "rst_stall");

        // Write r5, then reset mid-operation
        nxt();
        rst = 1'b0;
        commit(4'd5, 1'b0, 32'h0, 32'h1234);
        rs1 = 4'd5;
        dbg_idx = 4'd5;
        chk(S_RD1, 32'h1234, "r5_bypass");
        chk(S_DBG, 32'h0, "r5_dbg_old");
        nxt();
        rs1 = 4'd5;
        dbg_idx = 4'd5;
        chk(S_RD1, 32'h1234, "r5_read");
        chk(S_RET, 32'd1, "r5_retired");
        nxt();
        rst = 1'b1;
        rs1 = 4'd5;
        use_rs1 = 1'b1;
        chk(S_RD1, 32'h0, "rst2_rd1");
        chk(S_RET, 32'h0, "rst2_retired");
        chk(S_STL, 32'h0, "rst2_stall");

        // Writeback mux (commits with nothing pending)
        nxt();
        rst = 1'b0;
        commit(4'd3, 1'b1, 32'hAAAA0000, 32'h55);
        rs2 = 4'd3;
        chk(S_RD2, 32'hAAAA0000, "mux_mem");
        nxt();
        commit(4'd3, 1'b0, 32'hAAAA0000, 32'h55);
        rs2 = 4'd3;
        dbg_idx = 4'd3;
        chk(S_RD2, 32'h55, "mux_alu");
        chk(S_DBG, 32'hAAAA0000, "mux_dbg_mem");
        nxt();
        dbg_idx = 4'd3;
        chk(S_DBG, 32'h55, "mux_dbg_alu");
        chk(S_RET, 32'd2, "mux_retired");

        // Bypass vs. debug port
        nxt();
        commit(4'd7, 1'b0, 32'h0, 32'hDEADBEEF);
        rs1 = 4'd7;
        dbg_idx = 4'd7;
        chk(S_RD1, 32'hDEADBEEF, "byp_rd1");
        chk(S_DBG, 32'h0, "byp_dbg_old");
        nxt();
        dbg_idx = 4'd7;
        chk(S_DBG, 32'hDEADBEEF, "byp_dbg_new");
        chk(S_RET, 32'd3, "byp_retired");

        // RAW stall on r4
        nxt();
        issue(4'd4);
        chk(S_STL, 32'h0, "raw_issue");
        nxt();
        use_rs1 = 1'b1;
        rs1 = 4'd4;
        chk(S_STL, 32'h1, "raw_stall");
        nxt();
        use_rs1 = 1'b1;
        rs1 = 4'd4;
        commit(4'd4, 1'b0, 32'h0, 32'hCAFE0004);
        chk(S_STL, 32'h0, "raw_bypass_stall");
        chk(S_RD1, 32'hCAFE0004, "raw_bypass_rd1");
        nxt();
        use_rs1 = 1'b1;
        rs1 = 4'd4;
        chk(S_STL, 32'h0, "raw_clear");
        chk(S_RET, 32'd4, "raw_retired");

        // Scoreboard saturation on r9
        for (int i = 0; i < 3; i++) begin
            nxt();
            issue(4'd9);
            chk(S_STL, 32'h0, "sat_issue");
        end
        nxt();
        issue(4'd9);
        chk(S_STL, 32'h1, "sat_full");
        nxt();
        use_rs2 = 1'b1;
        rs2 = 4'd9;
        commit(4'd9, 1'b0, 32'h0, 32'h99);
        chk(S_STL, 32'h1, "sat_raw_no_bypass");
        chk(S_RD2, 32'h99, "sat_rd2");
        nxt();
        issue(4'd9);
        chk(S_STL, 32'h0, "sat_after_commit");
        nxt();
        issue(4'd9);
        chk(S_STL, 32'h1, "sat_full_again");
        chk(S_RET, 32'd5, "sat_retired");

        // Simultaneous issue and commit on r2
        nxt();
        issue(4'd2);
        chk(S_STL, 32'h0, "sim_first");
        nxt();
        issue(4'd2);
        commit(4'd2, 1'b0, 32'h0, 32'h22);
        chk(S_STL, 32'h0, "sim_issue_commit");
        nxt();
        use_rs1 = 1'b1;
        rs1 = 4'd2;
        chk(S_STL, 32'h1, "sim_pend_kept");
        chk(S_RD1, 32'h22, "sim_rd1");
        nxt();
        use_rs1 = 1'b1;
        rs1 = 4'd2;
        commit(4'd2, 1'b1, 32'h2222, 32'h0);
        chk(S_STL, 32'h0, "sim_drain");
        chk(S_RD1, 32'h2222, "sim_drain_rd1");
        nxt();
        chk(S_RET, 32'd7, "final_retired");

        nxt();
        @(negedge clk);
        #3;
        if (q_sel.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d expected 0",
                     q_sel.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
